// File: rtl/mw_lsu_sequencer.sv
// mw_lsu_sequencer: memory/writeback-stage load/store sequencer.
// Converts the registered MW control bundle into a single request/grant/response
// transaction on the data-memory port. It lane-aligns store data, extracts and
// extends load data, stalls the pipeline while an access is in flight and flags
// misaligned accesses without touching the bus.
module mw_lsu_sequencer #(
  parameter int OPS_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [OPS_W-1:0] rd_op,
  input  logic [OPS_W-1:0] wr_op,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  store_data,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             stall,
  output logic             load_valid,
  output logic [XLEN-1:0]  load_data,
  output logic             misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Fields captured in IDLE and held for the rest of the transaction.
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic            ld_byte_q;
  logic            ld_half_q;
  logic            ld_signed_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] load_data_q;

  // Decoded view of the current request.
  logic            access;
  logic            is_byte;
  logic            is_half;
  logic            is_signed;
  logic            aligned;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [4:0]      lane_shift;

  // Load extraction.
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] rdata_ext;
  logic [4:0]      rd_shift;

  assign access     = rd_en | wr_en;
  assign lane_shift = {addr[1:0], 3'b000};

  // Decode access size and signedness; a store has priority over a load, and
  // unknown op codes fall back to a full word access.
  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    if (wr_en) begin
      if (wr_op == OPS_W'(0)) begin
        is_byte = 1'b1;
      end else if (wr_op == OPS_W'(1)) begin
        is_half = 1'b1;
      end
    end else begin
      if (rd_op == OPS_W'(0)) begin
        is_byte   = 1'b1;
        is_signed = 1'b1;
      end else if (rd_op == OPS_W'(1)) begin
        is_half   = 1'b1;
        is_signed = 1'b1;
      end else if (rd_op == OPS_W'(3)) begin
        is_byte = 1'b1;
      end else if (rd_op == OPS_W'(4)) begin
        is_half = 1'b1;
      end
    end
  end

  // Alignment check, byte enables and store-lane placement for the request.
  always_comb begin
    aligned   = 1'b0;
    be_new    = 4'b1111;
    wdata_new = '0;
    if (is_byte) begin
      aligned = 1'b1;
      be_new  = 4'b0001 << addr[1:0];
    end else if (is_half) begin
      aligned = ~addr[0];
      be_new  = 4'b0011 << addr[1:0];
    end else begin
      aligned = (addr[1:0] == 2'b00);
      be_new  = 4'b1111;
    end
    if (wr_en) begin
      if (is_byte) begin
        wdata_new = {{(XLEN-8){1'b0}}, store_data[7:0]} << lane_shift;
      end else if (is_half) begin
        wdata_new = {{(XLEN-16){1'b0}}, store_data[15:0]} << lane_shift;
      end else begin
        wdata_new = store_data;
      end
    end
  end

  // Pull the addressed lane down to bit 0 and extend it to a full word.
  always_comb begin
    rd_shift      = {off_q, 3'b000};
    rdata_shifted = dmem_rdata >> rd_shift;
    rdata_ext     = rdata_shifted;
    if (ld_byte_q) begin
      rdata_ext = {{(XLEN-8){ld_signed_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
    end else if (ld_half_q) begin
      rdata_ext = {{(XLEN-16){ld_signed_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
    end
  end

  // Transaction state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: inputs only matter in IDLE, responses only in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (access && aligned) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          state_nxt = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the request fields when an aligned access is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      ld_byte_q   <= 1'b0;
      ld_half_q   <= 1'b0;
      ld_signed_q <= 1'b0;
      off_q       <= '0;
    end else if (state == IDLE && access && aligned) begin
      addr_q      <= {addr[XLEN-1:2], 2'b00};
      be_q        <= be_new;
      wdata_q     <= wdata_new;
      we_q        <= wr_en;
      ld_byte_q   <= is_byte;
      ld_half_q   <= is_half;
      ld_signed_q <= is_signed;
      off_q       <= addr[1:0];
    end
  end

  // Load result register, updated only by a response that arrives in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_data_q <= '0;
    end else if (state == WAIT && dmem_rvalid) begin
      load_data_q <= rdata_ext;
    end
  end

  // Bus outputs present the held fields only while a request is outstanding;
  // stall and misalign are forced low while reset is asserted.
  always_comb begin
    dmem_req   = (state == REQ);
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    if (state == REQ) begin
      dmem_we    = we_q;
      dmem_addr  = addr_q;
      dmem_be    = be_q;
      dmem_wdata = wdata_q;
    end
    stall      = rst & (((state == IDLE) & access & aligned) |
                        (state == REQ) | (state == WAIT));
    misalign   = rst & (state == IDLE) & access & ~aligned;
    load_valid = (state == DONE) & ~we_q;
    load_data  = load_data_q;
  end

endmodule

// File: tb/tb_mw_lsu_sequencer.sv
// Scoreboard bench for mw_lsu_sequencer: directed accesses push their expected
// bus request, load result or misalign event; a monitor checks each DUT event
// against the head of the matching queue. A small memory responder supplies
// grant/rvalid with programmable delays.
module tb_mw_lsu_sequencer;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  rd_op;
  logic [3:0]  wr_op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_load[$];
  logic [31:0] exp_mis[$];
  bus_t        mon_e;

  int total = 0;
  int bad   = 0;

  int gnt_wait = 0;
  int rv_wait  = 0;
  int req_cnt  = 0;
  int rv_cnt   = 0;
  bit pend_rd  = 0;

  mw_lsu_sequencer #(.OPS_W(4), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .rd_op       (rd_op),
    .wr_op       (wr_op),
    .addr        (addr),
    .store_data  (store_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .stall       (stall),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .misalign    (misalign)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic report_unexpected(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got=event want=none", name);
  endtask

  // Memory responder: grant after gnt_wait idle request cycles, read data
  // rv_wait cycles after the cycle following the grant.
  always @(negedge clk) begin
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    if (pend_rd) begin
      if (rv_cnt == rv_wait) begin
        dmem_rvalid = 1'b1;
        pend_rd     = 0;
      end else begin
        rv_cnt++;
      end
    end else if (dmem_req) begin
      if (req_cnt == gnt_wait) begin
        dmem_gnt = 1'b1;
        req_cnt  = 0;
        if (!dmem_we) begin
          pend_rd = 1;
          rv_cnt  = 0;
        end
      end else begin
        req_cnt++;
      end
    end
  end

  // Monitor: every request cycle, load pulse and misalign pulse is matched
  // against the head of its expectation queue.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (dmem_req) begin
        if (exp_bus.size() == 0) begin
          report_unexpected("bus_req");
        end else begin
          mon_e = exp_bus[0];
          check_output("req_addr", dmem_addr, mon_e.addr);
          check_output("req_be", 32'(dmem_be), 32'(mon_e.be));
          check_output("req_we", 32'(dmem_we), 32'(mon_e.we));
          if (mon_e.we) begin
            check_output("req_wdata", dmem_wdata, mon_e.wdata);
          end
          if (dmem_gnt) begin
            void'(exp_bus.pop_front());
          end
        end
      end
      if (load_valid) begin
        if (exp_load.size() == 0) begin
          report_unexpected("load_valid");
        end else begin
          check_output("load_data", load_data, exp_load.pop_front());
          check_output("load_valid_stall", 32'(stall), 32'd0);
        end
      end
      if (misalign) begin
        if (exp_mis.size() == 0) begin
          report_unexpected("misalign");
        end else begin
          void'(exp_mis.pop_front());
          check_output("misalign_stall", 32'(stall), 32'd0);
          check_output("misalign_req", 32'(dmem_req), 32'd0);
        end
      end
    end
  end

  // Issue one access, queue its expectations and count stalled cycles.
  task automatic apply_stimulus(input string name, input logic is_wr, input logic is_rd,
                                input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] sd, input int gw, input int rw,
                                input logic [31:0] rdata, input logic exp_mis_f,
                                input logic [3:0] exp_be, input logic [31:0] exp_wd,
                                input logic [31:0] exp_ld, input int exp_stall);
    bus_t e;
    int   n;
    bit   done;
    if (exp_mis_f) begin
      exp_mis.push_back(a);
    end else begin
      e.addr  = {a[31:2], 2'b00};
      e.be    = exp_be;
      e.wdata = exp_wd;
      e.we    = is_wr;
      exp_bus.push_back(e);
      if (!is_wr) begin
        exp_load.push_back(exp_ld);
      end
    end
    gnt_wait   = gw;
    rv_wait    = rw;
    dmem_rdata = rdata;
    wr_en      = is_wr;
    rd_en      = is_rd;
    wr_op      = op;
    rd_op      = op;
    addr       = a;
    store_data = sd;
    n    = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      #2;
      if (exp_mis_f) begin
        check_output({name, "_noreq"}, 32'(dmem_req), 32'd0);
      end
      if (stall) begin
        n++;
      end else begin
        done = 1;
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got=stuck want=done", name);
    end
    check_output({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int k;
    rst        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    rd_op      = '0;
    wr_op      = '0;
    addr       = '0;
    store_data = '0;
    dmem_gnt   = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    #12;
    check_output("rst_stall", 32'(stall), 32'd0);
    check_output("rst_req", 32'(dmem_req), 32'd0);
    check_output("rst_load_data", load_data, 32'd0);
    check_output("rst_be", 32'(dmem_be), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus("sw",  1, 0, 4'd2, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0, 2);
    apply_stimulus("sb",  1, 0, 4'd0, 32'h203, 32'h000000A5, 0, 0, 32'h0, 0, 4'b1000, 32'hA5000000, 32'h0, 2);
    apply_stimulus("sh",  1, 0, 4'd1, 32'h102, 32'hFFFF1234, 0, 0, 32'h0, 0, 4'b1100, 32'h12340000, 32'h0, 2);
    apply_stimulus("lb",  0, 1, 4'd0, 32'h301, 32'h0, 0, 0, 32'h12348056, 0, 4'b0010, 32'h0, 32'hFFFFFF80, 3);
    apply_stimulus("lbu", 0, 1, 4'd3, 32'h301, 32'h0, 0, 0, 32'h12348056, 0, 4'b0010, 32'h0, 32'h00000080, 3);
    apply_stimulus("lh",  0, 1, 4'd1, 32'h402, 32'h0, 0, 0, 32'h8001FFFF, 0, 4'b1100, 32'h0, 32'hFFFF8001, 3);
    apply_stimulus("lhu", 0, 1, 4'd4, 32'h402, 32'h0, 0, 0, 32'h8001FFFF, 0, 4'b1100, 32'h0, 32'h00008001, 3);
    apply_stimulus("lh0", 0, 1, 4'd1, 32'h400, 32'h0, 0, 0, 32'h12347FFF, 0, 4'b0011, 32'h0, 32'h00007FFF, 3);
    apply_stimulus("lw_mis", 0, 1, 4'd2, 32'h506, 32'h0, 0, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 0);
    apply_stimulus("sh_mis", 1, 0, 4'd1, 32'h001, 32'h0, 0, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 0);
    apply_stimulus("lw_op7", 0, 1, 4'd7, 32'h700, 32'h0, 0, 0, 32'h13579BDF, 0, 4'b1111, 32'h0, 32'h13579BDF, 3);
    apply_stimulus("both", 1, 1, 4'd2, 32'h104, 32'h01020304, 0, 0, 32'h0, 0, 4'b1111, 32'h01020304, 32'h0, 2);
    apply_stimulus("lw_slow", 0, 1, 4'd2, 32'h600, 32'h0, 3, 1, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'hCAFEF00D, 7);

    // Repeat the slow load, then assert reset while it waits for data.
    exp_bus.push_back('{addr: 32'h600, be: 4'b1111, wdata: 32'h0, we: 1'b0});
    gnt_wait   = 0;
    rv_wait    = 1;
    dmem_rdata = 32'h5555AAAA;
    rd_en      = 1'b1;
    rd_op      = 4'd2;
    addr       = 32'h600;
    k = 0;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (!dmem_gnt && k < 20);
    check_output("rst_test_gnt_seen", 32'(dmem_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_output("midrst_stall", 32'(stall), 32'd0);
    check_output("midrst_req", 32'(dmem_req), 32'd0);
    check_output("midrst_addr", dmem_addr, 32'd0);
    check_output("midrst_load_valid", 32'(load_valid), 32'd0);
    check_output("midrst_load_data", load_data, 32'hCAFEF00D & 32'h0);
    check_output("midrst_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    #2;
    rd_en = 1'b0;
    rst   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
    end
    check_output("late_rvalid_load_data", load_data, 32'd0);
    check_output("late_rvalid_stall", 32'(stall), 32'd0);

    check_output("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    check_output("load_queue_empty", 32'(exp_load.size()), 32'd0);
    check_output("mis_queue_empty", 32'(exp_mis.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mw_lsu_sequencer.md
Name: mw_lsu_sequencer

Overview:
- Memory/writeback-stage consumer of the registered DE->MW control bundle: rd_en, wr_en, rd_op, wr_op.
- Turns each load/store into a request/grant/response transaction on the data-memory port.
- Drives byte enables and lane-aligned store data; sign- or zero-extends load data.
- Holds the pipeline with stall until the access completes and flags misaligned accesses to the CSR/trap logic.

Parameters:
- OPS_W, 4, width of rd_op/wr_op (equals `DM_OPSLEN).
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd_en  in  1  MW-stage load request (from control register).
- wr_en  in  1  MW-stage store request.
- rd_op  in  OPS_W  load type: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU; others are treated as LW.
- wr_op  in  OPS_W  store type: 0 SB, 1 SH, 2 SW; others are treated as SW.
- addr  in  XLEN  effective byte address (ALU result).
- store_data  in  XLEN  rs2 value, unshifted.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  store data shifted into its byte lanes.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read word.
- stall  out  1  hold upstream pipeline.
- load_valid  out  1  one-cycle pulse: load_data valid.
- load_data  out  XLEN  extended load result, held until the next load completes.
- misalign  out  1  one-cycle pulse: misaligned access, no bus transaction.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall, load_valid, load_data, misalign.
- access = rd_en | wr_en. If both are high, the store wins and the load is ignored.
- Alignment rules:
  - Byte ops are always aligned.
  - Half ops are misaligned when addr[0]=1.
  - Word ops are misaligned when addr[1:0]!=0.
- State IDLE:
  - Access and aligned: assert stall combinationally. Register addr, byte enables, shifted wdata, we, and op/byte offset. Next state is REQ.
  - Access and misaligned: misalign=1 for that cycle, stall=0, state stays IDLE, no request.
  - No access: outputs idle.
- State REQ:
  - dmem_req=1 with the registered fields held stable until dmem_gnt.
  - On gnt, a store goes to DONE and a load goes to WAIT. dmem_req drops the cycle after gnt.
  - Gnt in the same cycle the request first appears is legal; minimum REQ dwell is 1 cycle.
- State WAIT:
  - dmem_req=0. On dmem_rvalid, capture the lane-selected and extended rdata into load_data. Next state is DONE.
  - dmem_rvalid while not in WAIT is ignored.
- State DONE: stall=0. load_valid=1 for one cycle if the access was a load. Next state is IDLE, unconditionally.
- stall = (IDLE & access & aligned) | REQ | WAIT.
- Latency with zero-wait memory (gnt in first REQ cycle, rvalid the next cycle):
  - Store: 3 cycles, 2 of them stalled.
  - Load: 4 cycles, 3 of them stalled.
- Byte enables:
  - Byte: be = 0001 << addr[1:0].
  - Half: be = 0011 << addr[1:0].
  - Word: be = 1111.
- Store data lanes: wdata = store_data << (8*addr[1:0]), with sub-word sources masked to 8/16 bits first.
- Load extraction: shift rdata right by 8*offset.
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-fill.
  - LW: pass through unchanged.
- Inputs rd_en/wr_en/addr are only sampled in IDLE. Changes during REQ/WAIT/DONE have no effect.
- Reset asserted mid-transaction returns to IDLE immediately. A pending response arriving after reset release is ignored.

Test Plan:
- SW addr=0x100 data=0xDEADBEEF, gnt in first REQ cycle -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; stall high 2 cycles; no load_valid.
- SB addr=0x203 data=0x000000A5 -> dmem_addr=0x200, be=1000, wdata=0xA5000000.
- LB addr=0x301, rdata=0x12348056, rvalid 1 cycle after gnt -> load_data=0xFFFFFF80, load_valid pulse 1 cycle; LBU same stimulus -> 0x00000080.
- LH addr=0x402, rdata=0x8001FFFF -> load_data=0xFFFF8001; LHU -> 0x00008001.
- LW addr=0x506 -> misalign pulse 1 cycle, stall=0, dmem_req never asserted; likewise SH addr=0x001.
- LW addr=0x600, gnt withheld 3 cycles then rvalid 2 cycles later -> dmem_req/addr stable throughout, stall high until DONE; assert rst=0 in WAIT on a repeat run -> stall=0 and outputs zero immediately, late rvalid ignored.
